// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 decode constants: prefix bytes, prefix-FSM state type and the
// default {ext, code} key map (up, down, left, right, space).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  localparam logic [8:0] PS2_KEY_UP    = 9'h175;
  localparam logic [8:0] PS2_KEY_DOWN  = 9'h172;
  localparam logic [8:0] PS2_KEY_LEFT  = 9'h16B;
  localparam logic [8:0] PS2_KEY_RIGHT = 9'h174;
  localparam logic [8:0] PS2_KEY_SPACE = 9'h029;

  // Slice 0 sits in the LSBs, so key 0 is "up" and key 4 is "space".
  localparam logic [44:0] PS2_DEFAULT_KEYS =
    {PS2_KEY_SPACE, PS2_KEY_RIGHT, PS2_KEY_LEFT, PS2_KEY_DOWN, PS2_KEY_UP};

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte stream in from the PS/2 controller, per-key events out to game logic.
// master = byte source / event consumer, slave = the decoder.
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS = 5
);

  logic [7:0]          ps2_key_data;
  logic                ps2_key_pressed;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_release;
  logic [8:0]          last_code;
  logic                code_valid;

  modport master (
    output ps2_key_data, ps2_key_pressed,
    input  key_held, key_pulse, key_release, last_code, code_valid
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed,
    output key_held, key_pulse, key_release, last_code, code_valid
  );

endinterface

// File: rtl/ps2_key_decoder_channel.sv
// One tracked key: held flag, press/release pulses and, with PS2_KEY_REPEAT_EN
// defined, an auto-repeat counter; otherwise a press produces a single pulse.
module ps2_key_channel #(
  parameter int CNT_W         = 32,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic make_i,
  input  logic break_i,
  output logic held_o,
  output logic pulse_o,
  output logic release_o
);

  logic held_q, pulse_q, release_q;

`ifdef PS2_KEY_REPEAT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counter holds cycles left until the next repeat; reaching 1 fires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q    <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      if (break_i) begin
        // Break outranks a repeat expiring on the same cycle.
        release_q <= held_q;
        held_q    <= 1'b0;
        cnt_q     <= '0;
      end else if (make_i && !held_q) begin
        held_q  <= 1'b1;
        pulse_q <= 1'b1;
        cnt_q   <= CNT_W'(REPEAT_DELAY);
      end else if (held_q) begin
        if (cnt_q == CNT_W'(1)) begin
          pulse_q <= 1'b1;
          cnt_q   <= CNT_W'(REPEAT_PERIOD);
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q    <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      pulse_q   <= make_i && !held_q;
      release_q <= break_i && held_q;
      if (break_i) begin
        held_q <= 1'b0;
      end else if (make_i) begin
        held_q <= 1'b1;
      end
    end
  end
`endif

  assign held_o    = held_q;
  assign pulse_o   = pulse_q;
  assign release_o = release_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM, key-code matcher and one
// ps2_key_channel per key. Optional auto-repeat: define PS2_KEY_REPEAT_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS      = 5,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES     = PS2_DEFAULT_KEYS,
  parameter int                    REPEAT_DELAY  = 25_000_000,
  parameter int                    REPEAT_PERIOD = 5_000_000,
  parameter int                    CNT_W         = 32
) (
  input logic               inclock,
  input logic               resetn,
  ps2_key_decoder_if.slave  bus
);

  ps2_state_e state_q, state_d;
  logic [8:0] last_code_q;
  logic       code_valid_q;
  logic       done, is_ext, is_brk;
  logic [8:0] code_d;
  logic [7:0] data;

  assign data = bus.ps2_key_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    done    = 1'b0;
    is_ext  = 1'b0;
    is_brk  = 1'b0;
    if (bus.ps2_key_pressed) begin
      unique case (state_q)
        ST_IDLE: begin
          if (data == PS2_EXT)      state_d = ST_EXT;
          else if (data == PS2_BRK) state_d = ST_BRK;
          else                      done = 1'b1;
        end
        ST_EXT: begin
          is_ext = 1'b1;
          if (data == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (data != PS2_EXT) done = 1'b1;
        end
        ST_BRK: begin
          is_brk = 1'b1;
          if (data == PS2_EXT)      state_d = ST_EXT_BRK;
          else if (data != PS2_BRK) done = 1'b1;
        end
        ST_EXT_BRK: begin
          is_ext = 1'b1;
          is_brk = 1'b1;
          if (data != PS2_EXT && data != PS2_BRK) done = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
      if (done) state_d = ST_IDLE;
    end
  end

  assign code_d = {is_ext, data};

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_code_q  <= '0;
      code_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      code_valid_q <= done;
      if (done) last_code_q <= code_d;
    end
  end

  logic [NUM_KEYS-1:0] held_w, pulse_w, release_w;

  // Duplicate slices simply make several channels see the same hit.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic hit;
    assign hit = done && (KEY_CODES[9*k +: 9] == code_d);

    ps2_key_channel #(
      .CNT_W         (CNT_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk       (inclock),
      .rst_n     (resetn),
      .make_i    (hit && !is_brk),
      .break_i   (hit && is_brk),
      .held_o    (held_w[k]),
      .pulse_o   (pulse_w[k]),
      .release_o (release_w[k])
    );
  end

  assign bus.key_held    = held_w;
  assign bus.key_pulse   = pulse_w;
  assign bus.key_release = release_w;
  assign bus.last_code   = last_code_q;
  assign bus.code_valid  = code_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a timestamp-based key model queues the
// expected output of each cycle; a monitor compares whenever DUT or model has an event.
module tb_ps2_key_decoder;

  localparam int NK  = 5;
  localparam int DLY = 40;
  localparam int PER = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if #(.NUM_KEYS(NK)) bus();

  ps2_key_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ({9'h029, 9'h174, 9'h16B, 9'h172, 9'h175}),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER),
    .CNT_W         (8)
  ) dut (
    .inclock (clk),
    .resetn  (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int            cyc;
    logic          cv;
    logic [8:0]    last;
    logic [NK-1:0] pulse;
    logic [NK-1:0] rel;
    logic [NK-1:0] held;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse0_cnt = 0, pulse4_cnt = 0, rel4_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: prefix flags, held set and absolute repeat timestamps.
  logic [8:0] keys_m [NK] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029};
  bit         held_m [NK];
  int         next_rep [NK];
  bit         ext_m, brk_m;
  logic [8:0] last_m;

  task automatic model_reset();
    ext_m = 0;
    brk_m = 0;
    last_m = '0;
    for (int k = 0; k < NK; k++) begin
      held_m[k] = 0;
      next_rep[k] = 0;
    end
  endtask

  task automatic model_step(input bit s, input logic [7:0] d);
    exp_t e;
    logic [8:0] code;
    int o;
    o = cyc + 1;
    e.cyc = o;
    e.cv = 1'b0;
    e.pulse = '0;
    e.rel = '0;
    if (s) begin
      if (d == 8'hE0) ext_m = 1;
      else if (d == 8'hF0) brk_m = 1;
      else begin
        code = {ext_m, d};
        e.cv = 1'b1;
        last_m = code;
        for (int k = 0; k < NK; k++) begin
          if (keys_m[k] == code) begin
            if (brk_m) begin
              if (held_m[k]) begin
                held_m[k] = 0;
                e.rel[k] = 1'b1;
              end
            end else if (!held_m[k]) begin
              held_m[k] = 1;
              e.pulse[k] = 1'b1;
              next_rep[k] = o + DLY;
            end
          end
        end
        ext_m = 0;
        brk_m = 0;
      end
    end
`ifdef PS2_KEY_REPEAT_EN
    for (int k = 0; k < NK; k++) begin
      if (held_m[k] && next_rep[k] == o) begin
        e.pulse[k] = 1'b1;
        next_rep[k] = next_rep[k] + PER;
      end
    end
`endif
    e.last = last_m;
    for (int k = 0; k < NK; k++) e.held[k] = held_m[k];
    if (e.cv || (|e.pulse) || (|e.rel)) q.push_back(e);
  endtask

  task automatic cycle(input bit s, input logic [7:0] d);
    @(negedge clk);
    bus.ps2_key_pressed = s;
    bus.ps2_key_data = s ? d : 8'($urandom);
    model_step(s, d);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic send_make(input int k);
    logic [8:0] c;
    c = keys_m[k];
    if (c[8]) cycle(1'b1, 8'hE0);
    cycle(1'b1, c[7:0]);
  endtask

  task automatic send_break(input int k);
    logic [8:0] c;
    c = keys_m[k];
    if (c[8]) cycle(1'b1, 8'hE0);
    cycle(1'b1, 8'hF0);
    cycle(1'b1, c[7:0]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_held"},    bus.key_held, 0);
    check({tag, "_pulse"},   bus.key_pulse, 0);
    check({tag, "_release"}, bus.key_release, 0);
    check({tag, "_last"},    bus.last_code, 0);
    check({tag, "_valid"},   bus.code_valid, 0);
  endtask

  // Monitor: every cycle, #1 after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      pulse0_cnt += int'(bus.key_pulse[0]);
      pulse4_cnt += int'(bus.key_pulse[4]);
      rel4_cnt   += int'(bus.key_release[4]);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("stale_expectation_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        check("code_valid",  bus.code_valid,  q[0].cv);
        check("last_code",   bus.last_code,   q[0].last);
        check("key_pulse",   bus.key_pulse,   q[0].pulse);
        check("key_release", bus.key_release, q[0].rel);
        check("key_held",    bus.key_held,    q[0].held);
        void'(q.pop_front());
      end else if (bus.code_valid || (|bus.key_pulse) || (|bus.key_release)) begin
        check("unexpected_event", {bus.key_pulse, bus.key_release, bus.code_valid}, 0);
      end
    end
  end

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h29, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hE1, 8'hAA, 8'hFA};

  initial begin
    int p0, p4, r4;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_key_data = 8'h00;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Space make then break.
    p4 = pulse4_cnt; r4 = rel4_cnt;
    cycle(1'b1, 8'h29); idle(3);
    check("space_held_after_make", bus.key_held[4], 1);
    cycle(1'b1, 8'hF0); cycle(1'b1, 8'h29); idle(3);
    check("space_pulses", pulse4_cnt - p4, 1);
    check("space_releases", rel4_cnt - r4, 1);
    check("space_last_code", bus.last_code, 9'h029);

    // Typematic makes while held are ignored.
    p0 = pulse0_cnt;
    repeat (5) begin send_make(0); idle(1); end
    check("typematic_pulses", pulse0_cnt - p0, 1);
    check("typematic_held", bus.key_held[0], 1);
    send_break(0); idle(3);

    // Long hold: press plus repeats at DLY, DLY+PER, DLY+2*PER.
    p0 = pulse0_cnt;
    send_make(0); idle(DLY + 2 * PER + 5); send_break(0); idle(3);
`ifdef PS2_KEY_REPEAT_EN
    check("hold_pulse_count", pulse0_cnt - p0, 4);
`else
    check("hold_pulse_count", pulse0_cnt - p0, 1);
`endif

    // Non-extended 75 matches nothing.
    cycle(1'b1, 8'h75); idle(2);
    check("plain75_last_code", bus.last_code, 9'h075);
    check("plain75_held", bus.key_held, 0);

    // Break lands on the cycle the first repeat would fire.
    p4 = pulse4_cnt; r4 = rel4_cnt;
    cycle(1'b1, 8'h29); cycle(1'b1, 8'hF0); idle(DLY - 2); cycle(1'b1, 8'h29); idle(PER + 3);
    check("aligned_break_pulses", pulse4_cnt - p4, 1);
    check("aligned_break_releases", rel4_cnt - r4, 1);

    // Reset after a held key and a dangling E0.
    send_make(1); cycle(1'b1, 8'hE0); idle(2);
    @(negedge clk);
    bus.ps2_key_pressed = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h6B); idle(2);
    check("post_reset_last_code", bus.last_code, 9'h06B);
    check("post_reset_held", bus.key_held, 0);

    // Randomised byte stream with occasional long holds.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 9)];
      cycle(1'b1, b);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(DLY - 5, DLY + 2 * PER));
      else idle($urandom_range(0, 3));
    end

    if (ext_m || brk_m) cycle(1'b1, 8'hAA);
    for (int k = 0; k < NK; k++) if (held_m[k]) send_break(k);
    idle(5);
    check("final_held", bus.key_held, 0);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 scan-code decoder sitting between `PS2_Controller` and the game logic. It consumes the controller's byte stream, tracks E0 (extended) and F0 (break) prefixes, and matches completed codes against `NUM_KEYS` configurable key codes. Per key it produces a held level, a press/repeat pulse and a release pulse, replacing fixed-period polled flags with true make/break tracking and optional auto-repeat.

## Interface
- `NUM_KEYS`, 5: number of tracked keys (1..16).
- `KEY_CODES`, {9'h029, 9'h174, 9'h16B, 9'h172, 9'h175}: packed `9*NUM_KEYS`-bit map; slice k = {ext, code} for key k (default: 0 up, 1 down, 2 left, 3 right, 4 space).
- `REPEAT_DELAY`, 25_000_000: cycles from press pulse to first repeat pulse.
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent repeat pulses.
- `CNT_W`, 32: repeat counter width; must hold both repeat values.

- `inclock` in 1: system clock (50 MHz).
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_key_data` in 8: byte from `PS2_Controller`.
- `ps2_key_pressed` in 1: one-cycle strobe qualifying `ps2_key_data`.
- `key_held` out NUM_KEYS: level, key currently down.
- `key_pulse` out NUM_KEYS: one-cycle pulse on press and on each auto-repeat.
- `key_release` out NUM_KEYS: one-cycle pulse on break.
- `last_code` out 9: {ext, code} of last completed make or break code, matched or not.
- `code_valid` out 1: one-cycle pulse when `last_code` updates.

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0). Only strobed bytes advance it.
- IDLE: E0 -> EXT; F0 -> BRK; other byte -> complete make {0,byte}.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> complete make {1,byte}.
- BRK: E0 -> EXT_BRK; F0 -> stay BRK; other -> complete break {0,byte}. EXT_BRK: E0/F0 -> stay; other -> complete break {1,byte}. Every completion returns to IDLE.
- Completion: `last_code` <= code, `code_valid` pulses. Each key k whose slice equals code acts:
  - make, not held: `key_held[k]` set, `key_pulse[k]` pulses, repeat counter loads `REPEAT_DELAY`.
  - make, already held (keyboard typematic): ignored; no pulse.
  - break: `key_held[k]` cleared, `key_release[k]` pulses, counter stops; break of an unheld key produces no pulse.
- Unmatched codes (incl. E1, AA, FA) update `last_code` only.
- Duplicate slices in `KEY_CODES`: all matching keys act identically.

## Timing
- All outputs registered; reset value 0 for every output, FSM IDLE, counters 0.
- Strobe cycle t completing a code -> `key_pulse`/`key_release`/`code_valid`/`last_code`/`key_held` change at t+1.
- Repeat: press pulse at t+1, first repeat pulse at t+1+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles while held.
- Break completing on the same cycle a repeat would fire: break wins; no repeat pulse.
- Prefix bytes produce no outputs; no timeout between prefix and code byte.
- Reset mid-sequence (e.g. after E0): all held state and prefix lost; next byte decoded from IDLE.

## Configuration
- `PS2_KEY_REPEAT_EN` defined: per-key repeat counters built; behaviour as above.
- Undefined: no counters; `key_pulse` fires only on press; `REPEAT_DELAY`/`REPEAT_PERIOD`/`CNT_W` ignored.

## Structure
- Shared package `ps2_pkg`: byte constants `PS2_EXT` (E0), `PS2_BRK` (F0), FSM state typedef, default arrow/space 9-bit codes.
- Sub-module `ps2_key_channel`, instantiated `NUM_KEYS` times by generate: held flag, release/press logic, repeat counter; top holds FSM and matcher.

## Test plan
- Strobe 29 then F0 29 -> `key_pulse[4]` and `key_held[4]` at t+1; `key_release[4]` after F0 29; `last_code`=9'h029 both times.
- E0 75, hold 25_000_000+2×5_000_000 cycles, E0 F0 75 -> 1 press + 3 repeat pulses on bit 0, then release; with macro undefined exactly 1 pulse.
- E0 75 repeated 4 times while held -> single `key_pulse[0]`, `key_held[0]` stays 1.
- Strobe 75 without E0 -> no key activity, `last_code`=9'h075, `code_valid` pulses.
- E0, assert `resetn` low, release, strobe 6B -> all outputs 0 during reset; afterwards `last_code`=9'h06B, no key match.
- Break F0 29 aligned with first repeat expiry cycle -> `key_release[4]` only, no `key_pulse[4]`.
